// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int XLEN = 32;

  // Access size the fetch port always uses (one 32-bit instruction word).
  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT,
    ARB_RSP
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DATA
  } arb_owner_e;

  // Command latched at grant time and replayed on the bus until accepted.
  typedef struct packed {
    logic [XLEN-1:0] adr;
    logic            we;
    logic [XLEN-1:0] wdata;
    logic [2:0]      size;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data requesters. Data normally wins;
// after FAIR_LIMIT consecutive data wins over a waiting fetch, fetch wins one.
module mem_arb_prio
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned FAIR_LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic if_win,
  output logic d_win
);

  localparam logic [3:0] LIMIT = 4'(FAIR_LIMIT);

  logic [3:0] fair_cnt;

  // Combinational winner select; only meaningful while the arbiter is idle.
  // NOTE: every output gets a value before any branch, so no latch is inferred.
  always_comb begin
    d_win  = 1'b0;
    if_win = 1'b0;
    if (arb_en) begin
      d_win  = d_req && (!if_req || (fair_cnt < LIMIT));
      if_win = if_req && !d_win;
    end
  end

  // Count data wins taken while a fetch was waiting; any other grant clears it.
  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fair_cnt <= '0;
    end else if (d_win && if_req) begin
      fair_cnt <= fair_cnt + 4'd1;
    end else if (d_win || if_win) begin
      fair_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between the fetch and data ports of the
// core, with one transaction outstanding at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned FAIR_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  // fetch port
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_adr_i,
  input  logic            if_flush_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [31:0]     if_rdata_o,
  // data port
  input  logic            d_req_i,
  input  logic [XLEN-1:0] d_adr_i,
  input  logic            d_we_i,
  input  logic [XLEN-1:0] d_wdata_i,
  input  logic [2:0]      d_size_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  // memory bus
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_adr_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [2:0]      mem_size_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  arb_state_e      state_q, state_d;
  arb_owner_e      owner_q, owner_d;
  mem_cmd_t        cmd_q, cmd_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            drop_q, drop_d;

  logic arb_en;
  logic if_win;
  logic d_win;

  // Grants are only offered while idle; holding reset also blocks them so
  // every output reads 0 for the whole reset period.
  assign arb_en = reset_n && (state_q == ARB_IDLE);

  mem_arb_prio #(
    .FAIR_LIMIT (FAIR_LIMIT)
  ) u_prio (
    .clk     (clk),
    .reset_n (reset_n),
    .arb_en  (arb_en),
    .if_req  (if_req_i),
    .d_req   (d_req_i),
    .if_win  (if_win),
    .d_win   (d_win)
  );

  // Next-state logic: latch the winner's command, track the bus handshake,
  // capture the response and remember whether a flushed fetch must be dropped.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
    drop_d  = drop_q;

    unique case (state_q)
      ARB_IDLE: begin
        drop_d = 1'b0;
        if (d_win) begin
          cmd_d   = '{adr: d_adr_i, we: d_we_i, wdata: d_wdata_i, size: d_size_i};
          owner_d = OWN_DATA;
          state_d = ARB_REQ;
        end else if (if_win) begin
          cmd_d   = '{adr: if_adr_i, we: 1'b0, wdata: '0, size: SIZE_WORD};
          owner_d = OWN_IF;
          // A branch in the grant cycle already makes this fetch stale.
          drop_d  = if_flush_i;
          state_d = ARB_REQ;
        end
      end

      ARB_REQ: begin
        if (if_flush_i && (owner_q == OWN_IF)) drop_d = 1'b1;
        // A response arriving together with the bus grant is a protocol
        // violation by the bus and is deliberately not observed here.
        if (mem_gnt_i) state_d = ARB_WAIT;
      end

      ARB_WAIT: begin
        if (if_flush_i && (owner_q == OWN_IF)) drop_d = 1'b1;
        if (mem_rvalid_i) begin
          rdata_d = cmd_q.we ? '0 : mem_rdata_i;
          state_d = ARB_RSP;
        end
      end

      ARB_RSP: begin
        owner_d = OWN_NONE;
        drop_d  = 1'b0;
        state_d = ARB_IDLE;
      end

      default: begin
        owner_d = OWN_NONE;
        drop_d  = 1'b0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, owner, command and response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
      cmd_q   <= '0;
      rdata_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
      drop_q  <= drop_d;
    end
  end

  assign if_gnt_o    = if_win;
  assign d_gnt_o     = d_win;

  assign mem_req_o   = (state_q == ARB_REQ);
  assign mem_adr_o   = cmd_q.adr;
  assign mem_we_o    = cmd_q.we;
  assign mem_wdata_o = cmd_q.wdata;
  assign mem_size_o  = cmd_q.size;

  // A flush arriving in the response cycle itself also discards the fetch.
  assign if_rvalid_o = (state_q == ARB_RSP) && (owner_q == OWN_IF) && !drop_q && !if_flush_i;
  assign d_rvalid_o  = (state_q == ARB_RSP) && (owner_q == OWN_DATA);

  assign if_rdata_o  = if_rvalid_o ? rdata_q[31:0] : 32'h0;
  assign d_rdata_o   = d_rvalid_o  ? rdata_q       : '0;

endmodule
